// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key expansion: derives round key K[r-1] from K[r] and r.
// Loads take 5 clocks to done; one shared S-box serves one byte per clock, and ready is ignored while busy.
module inv_key_schedule (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] in,
    input  logic [3:0]   round,
    input  logic         ready,
    output logic [127:0] out,
    output logic         done,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, SUB, FIN} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset of entry x is (255-x)*8.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t        state;
    logic [127:0]  key;
    logic [3:0]    rnd;
    logic [1:0]    idx;
    logic [31:0]   sub_word;

    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   p0, p1, p2, p3, t;
    logic [1:0]    sel;
    logic [7:0]    t_byte;

    always_comb begin
        w0     = key[127:96];
        w1     = key[95:64];
        w2     = key[63:32];
        w3     = key[31:0];
        p3     = w3 ^ w2;
        p2     = w2 ^ w1;
        p1     = w1 ^ w0;
        t      = {p3[23:0], p3[31:24]};
        p0     = w0 ^ sub_word ^ {rcon(rnd), 24'h0};
        // byte index 0 addresses the most significant byte
        sel    = 2'd3 - idx;
        t_byte = t[{sel, 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            key      <= '0;
            rnd      <= '0;
            idx      <= '0;
            sub_word <= '0;
            out      <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (ready) begin
                        if (round >= 4'd1 && round <= 4'd10) begin
                            key   <= in;
                            rnd   <= round;
                            idx   <= 2'd0;
                            busy  <= 1'b1;
                            state <= SUB;
                        end else begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                end
                SUB: begin
                    sub_word[{sel, 3'b000} +: 8] <= sbox(t_byte);
                    idx <= idx + 2'd1;
                    if (idx == 2'd3)
                        state <= FIN;
                end
                FIN: begin
                    out   <= {p0, p1, p2, p3};
                    done  <= 1'b1;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule: FIPS-197 vectors, corner sequences, random keys vs a GF(2^8) model.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] in = '0;
    logic [3:0]   round = '0;
    logic         ready = 1'b0;
    logic [127:0] out;
    logic         done, busy, err;

    inv_key_schedule dut (
        .clk(clk), .reset(reset), .in(in), .round(round), .ready(ready),
        .out(out), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_last = '0;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   r;
        logic [127:0] prev;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---- reference model: S-box built from the field inverse and affine map ----
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] v = 8'h01;
        for (int i = 1; i < r; i++) v = gf_mul(v, 8'h02);
        return v;
    endfunction

    function automatic logic [127:0] prev_key(input logic [127:0] k, input int r);
        logic [31:0] w[4];
        logic [31:0] p[4];
        logic [31:0] rot;
        logic [31:0] sw;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        p[3] = w[3] ^ w[2];
        p[2] = w[2] ^ w[1];
        p[1] = w[1] ^ w[0];
        rot = {p[3][23:0], p[3][31:24]};
        for (int i = 0; i < 4; i++) sw[31 - 8*i -: 8] = sbox_ref(rot[31 - 8*i -: 8]);
        p[0] = w[0] ^ sw ^ {rcon_ref(r), 24'h0};
        return {p[0], p[1], p[2], p[3]};
    endfunction

    // Launch one load; report the edge index (0 = load edge) at which done rose and the busy trace.
    task automatic run_job(input logic [127:0] k, input logic [3:0] r,
                           output int lat, output logic [5:0] bmask);
        @(negedge clk);
        in = k; round = r; ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        lat = -1;
        bmask = '0;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            if (n < 6) bmask[n] = busy;
            if (done) begin lat = n; break; end
            if (n < 20) @(posedge clk);
        end
    endtask

    task automatic idle_no_done(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(name, seen, 0);
    endtask

    logic [127:0] kr[11];
    int           lat;
    logic [5:0]   bm;
    logic [127:0] cur, kb, exp_b;
    logic [3:0]   rb, rr;
    int           d5, d11, stray;

    initial begin
        kr[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        kr[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        kr[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        kr[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        kr[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        kr[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        kr[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        kr[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        kr[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        kr[9]  = 128'hac7766f319fadc2128d12941575c006e;
        kr[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 10; i++) begin
            vecs[i].key  = kr[10 - i];
            vecs[i].r    = 4'(10 - i);
            vecs[i].prev = kr[9 - i];
        end

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", out, 128'h0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;

        // first vector: latency, busy window, done width
        run_job(kr[1], 4'd1, lat, bm);
        chk("r1_latency", lat, 5);
        chk("r1_out", out, kr[0]);
        chk("r1_err", err, 0);
        chk("r1_busy_trace", bm, 6'b011111);
        exp_last = kr[0];
        @(negedge clk);
        chk("r1_done_width", done, 0);

        // walk the full schedule down from K10, feeding each result back
        cur = vecs[0].key;
        for (int i = 0; i < 10; i++) begin
            run_job(cur, vecs[i].r, lat, bm);
            chk($sformatf("chain_r%0d_latency", vecs[i].r), lat, 5);
            chk($sformatf("chain_r%0d_out", vecs[i].r), out, vecs[i].prev);
            cur = out;
        end
        exp_last = kr[0];

        // ready pulses at E2 and E5 must not disturb the running job
        @(negedge clk);
        in = kr[2]; round = 4'd2; ready = 1'b1;
        @(posedge clk);                       // E0
        #1 ready = 1'b0; in = {4{$urandom}}; round = 4'd7;
        @(posedge clk);                       // E1
        #1 ready = 1'b1;
        @(posedge clk);                       // E2
        #1 ready = 1'b0; in = {4{$urandom}}; round = 4'd0;
        repeat (2) @(posedge clk);            // E3, E4
        #1 ready = 1'b1;
        @(posedge clk);                       // E5
        #1 ready = 1'b0;
        @(negedge clk);
        chk("ignore_done", done, 1);
        chk("ignore_out", out, kr[1]);
        chk("ignore_err", err, 0);
        exp_last = kr[1];
        @(negedge clk);
        chk("ignore_e5_no_restart", busy, 0);
        idle_no_done("ignore_no_extra_done", 8);

        // out-of-range round indices
        for (int k = 0; k < 2; k++) begin
            rr = (k == 0) ? 4'd0 : 4'd11;
            run_job({4{$urandom}}, rr, lat, bm);
            chk($sformatf("bad_r%0d_latency", rr), lat, 0);
            chk($sformatf("bad_r%0d_err", rr), err, 1);
            chk($sformatf("bad_r%0d_out_held", rr), out, exp_last);
            chk($sformatf("bad_r%0d_busy", rr), bm, 6'b0);
            @(negedge clk);
            chk($sformatf("bad_r%0d_done_width", rr), done, 0);
            chk($sformatf("bad_r%0d_err_held", rr), err, 1);
            chk($sformatf("bad_r%0d_busy_after", rr), busy, 0);
        end

        // asynchronous reset while substituting
        @(negedge clk);
        in = kr[5]; round = 4'd5; ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (3) @(posedge clk);            // E3
        #3 reset = 1'b1;
        #1;
        chk("areset_out", out, 128'h0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_last = '0;
        idle_no_done("areset_no_done", 10);
        run_job(kr[1], 4'd1, lat, bm);
        chk("areset_fresh_latency", lat, 5);
        chk("areset_fresh_out", out, kr[0]);
        exp_last = kr[0];

        // back-to-back: ready held high, second job taken at E6
        kb = {$urandom, $urandom, $urandom, $urandom};
        rb = 4'($urandom_range(1, 10));
        exp_b = prev_key(kb, rb);
        d5 = 0; d11 = 0; stray = 0;
        @(negedge clk);
        in = kr[1]; round = 4'd1; ready = 1'b1;
        @(posedge clk);
        #1 in = kb; round = rb;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (done) begin
                if (n == 5) begin d5 = 1; chk("b2b_first_out", out, kr[0]); end
                else if (n == 11) begin d11 = 1; chk("b2b_second_out", out, exp_b); end
                else stray++;
            end
            @(posedge clk);
            if (n == 5) #1 ready = 1'b0;
        end
        chk("b2b_first_done", d5, 1);
        chk("b2b_second_done", d11, 1);
        chk("b2b_stray_done", stray, 0);
        exp_last = exp_b;

        // random keys, mostly valid rounds, against the model
        for (int i = 0; i < 40; i++) begin
            kb = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0)
                rr = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(11, 15));
            else
                rr = 4'($urandom_range(1, 10));
            run_job(kb, rr, lat, bm);
            if (rr >= 4'd1 && rr <= 4'd10) begin
                exp_last = prev_key(kb, rr);
                chk($sformatf("rand%0d_latency", i), lat, 5);
                chk($sformatf("rand%0d_out", i), out, exp_last);
                chk($sformatf("rand%0d_err", i), err, 0);
            end else begin
                chk($sformatf("rand%0d_bad_latency", i), lat, 0);
                chk($sformatf("rand%0d_bad_out", i), out, exp_last);
                chk($sformatf("rand%0d_bad_err", i), err, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
